// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - parametrised UART frame transmitter with valid/ready input
//
// Serialises one word per frame: start bit, DATA_BITS data bits LSB first,
// optional parity bit, then STOP_BITS stop bits. A word offered during the
// final cycle of the last stop bit is accepted and starts the next frame with
// no idle bit in between.
//
// Ports:
//   CLOCK_50    in   system clock, rising edge
//   Reset       in   asynchronous active-high reset
//   Tx_Data     in   payload word, captured on handshake
//   Tx_Valid    in   upstream offers Tx_Data
//   Tx_Ready    out  word accepted on this cycle's edge if Tx_Valid
//   Serial_Data out  registered UART line, idle high
//   Busy        out  a frame is on the line
//   Frame_Done  out  pulse on the final cycle of the last stop bit

module uart_tx_frame #(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 460800,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 CLOCK_50,
    input  logic                 Reset,
    input  logic [DATA_BITS-1:0] Tx_Data,
    input  logic                 Tx_Valid,
    output logic                 Tx_Ready,
    output logic                 Serial_Data,
    output logic                 Busy,
    output logic                 Frame_Done
);

    localparam int BIT_TICKS = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int TW        = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int CW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_frame: DATA_BITS must be in 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_frame: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx_frame: STOP_BITS must be 1 or 2");
        end
        if (BIT_TICKS < 2) begin : g_bad_bit_ticks
            $error("uart_tx_frame: CLK_HZ/BAUD gives fewer than 2 ticks per bit");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q,    state_d;
    logic [TW-1:0]          tick_q,     tick_d;
    logic [CW-1:0]          bit_cnt_q,  bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q,    shift_d;
    logic                   parity_q,   parity_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   serial_q,   serial_d;
    // Keeps Tx_Ready low until the first clock after Reset is released.
    logic                   ready_en_q, ready_en_d;

    logic tick_wrap;
    logic last_stop;
    logic xfer;
    logic parity_calc;

    assign tick_wrap   = (tick_q == TICK_LAST);
    assign last_stop   = (state_q == S_STOP) && (stop_cnt_q == STOP_LAST) && tick_wrap;
    assign Tx_Ready    = ((state_q == S_IDLE) && ready_en_q) || last_stop;
    assign xfer        = Tx_Valid && Tx_Ready;
    assign parity_calc = (PARITY == 1) ? ~^Tx_Data : ^Tx_Data;

    assign Serial_Data = serial_q;
    assign Busy        = (state_q != S_IDLE);
    assign Frame_Done  = last_stop;

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_wrap ? '0 : tick_q + TW'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        stop_cnt_d = stop_cnt_q;
        serial_d   = serial_q;
        ready_en_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                tick_d   = '0;
                serial_d = 1'b1;
                if (xfer) begin
                    state_d   = S_START;
                    shift_d   = Tx_Data;
                    parity_d  = parity_calc;
                    bit_cnt_d = '0;
                    serial_d  = 1'b0;
                end
            end

            S_START: begin
                if (tick_wrap) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                    serial_d  = shift_q[0];
                end
            end

            S_DATA: begin
                if (tick_wrap) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        if (PARITY != 0) begin
                            state_d  = S_PARITY;
                            serial_d = parity_q;
                        end else begin
                            state_d    = S_STOP;
                            stop_cnt_d = 1'b0;
                            serial_d   = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                        shift_d   = shift_q >> 1;
                        // Next bit is drawn before the shift lands so the line
                        // and the shift register stay aligned.
                        serial_d  = shift_q[1];
                    end
                end
            end

            S_PARITY: begin
                if (tick_wrap) begin
                    state_d    = S_STOP;
                    stop_cnt_d = 1'b0;
                    serial_d   = 1'b1;
                end
            end

            S_STOP: begin
                if (tick_wrap) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        if (xfer) begin
                            // Back-to-back frame: restart the bit timer so
                            // phase does not carry over.
                            state_d   = S_START;
                            tick_d    = '0;
                            shift_d   = Tx_Data;
                            parity_d  = parity_calc;
                            bit_cnt_d = '0;
                            serial_d  = 1'b0;
                        end else begin
                            state_d  = S_IDLE;
                            serial_d = 1'b1;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d  = S_IDLE;
                tick_d   = '0;
                serial_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            stop_cnt_q <= 1'b0;
            serial_q   <= 1'b1;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            stop_cnt_q <= stop_cnt_d;
            serial_q   <= serial_d;
            ready_en_q <= ready_en_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - self-checking bench for uart_tx_frame

module tb_uart_tx_frame;

    localparam int BT = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] tx_word;
    logic [3:0] tx_valid;
    logic [3:0] tx_ready;
    logic [3:0] serial;
    logic [3:0] busy;
    logic [3:0] done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .CLOCK_50(clk), .Reset(rst), .Tx_Data(tx_word[7:0]), .Tx_Valid(tx_valid[0]),
        .Tx_Ready(tx_ready[0]), .Serial_Data(serial[0]), .Busy(busy[0]), .Frame_Done(done[0]));

    uart_tx_frame #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7e1 (
        .CLOCK_50(clk), .Reset(rst), .Tx_Data(tx_word[6:0]), .Tx_Valid(tx_valid[1]),
        .Tx_Ready(tx_ready[1]), .Serial_Data(serial[1]), .Busy(busy[1]), .Frame_Done(done[1]));

    uart_tx_frame #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_7o1 (
        .CLOCK_50(clk), .Reset(rst), .Tx_Data(tx_word[6:0]), .Tx_Valid(tx_valid[2]),
        .Tx_Ready(tx_ready[2]), .Serial_Data(serial[2]), .Busy(busy[2]), .Frame_Done(done[2]));

    uart_tx_frame #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2)) u_9n2 (
        .CLOCK_50(clk), .Reset(rst), .Tx_Data(tx_word), .Tx_Valid(tx_valid[3]),
        .Tx_Ready(tx_ready[3]), .Serial_Data(serial[3]), .Busy(busy[3]), .Frame_Done(done[3]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_idle(input int i);
        chk("idle_serial", 0, serial[i], 1'b1);
        chk("idle_busy",   0, busy[i],   1'b0);
        chk("idle_ready",  0, tx_ready[i], 1'b1);
        chk("idle_done",   0, done[i],   1'b0);
    endtask

    // Expected line levels are built bit by bit from the frame format, then
    // each bit is stretched to BT clocks.
    task automatic run_frame(input int i, input int db, input int par, input int sb,
                             input logic [8:0] w, input bit do_start, input bit hold,
                             input logic [8:0] nxt, input int glitch);
        logic q[$];
        int   ones;
        int   fl;
        q.push_back(1'b0);
        ones = 0;
        for (int b = 0; b < db; b++) begin
            q.push_back(w[b]);
            ones += int'(w[b]);
        end
        if (par == 1) q.push_back(logic'((ones % 2) == 0));
        else if (par == 2) q.push_back(logic'((ones % 2) == 1));
        for (int s = 0; s < sb; s++) q.push_back(1'b1);
        fl = q.size() * BT;

        if (do_start) begin
            chk("ready_pre", 0, tx_ready[i], 1'b1);
            tx_word     = w;
            tx_valid[i] = 1'b1;
            step();
        end
        for (int k = 1; k <= fl; k++) begin
            if (k == 1 && !hold) tx_valid[i] = 1'b0;
            chk("serial",     k, serial[i],   q[(k - 1) / BT]);
            chk("frame_done", k, done[i],     logic'(k == fl));
            chk("tx_ready",   k, tx_ready[i], logic'(k == fl));
            chk("busy",       k, busy[i],     1'b1);
            if (k == glitch) begin
                tx_valid[i] = 1'b1;
                tx_word     = 9'h011;
            end
            if (glitch > 0 && k == glitch + 1) begin
                tx_valid[i] = 1'b0;
                tx_word     = 9'($urandom);
            end
            if (k == fl && hold) tx_word = nxt;
            step();
        end
    endtask

    initial begin
        logic [8:0] w;
        logic       e;
        rst      = 1'b1;
        tx_valid = 4'b0000;
        tx_word  = 9'h000;

        #2;
        for (int i = 0; i < 4; i++) begin
            chk("rst_serial", 0, serial[i],   1'b1);
            chk("rst_busy",   0, busy[i],     1'b0);
            chk("rst_done",   0, done[i],     1'b0);
            chk("rst_ready",  0, tx_ready[i], 1'b0);
        end
        step();
        step();
        chk("rst_ready_held", 0, tx_ready[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_before_first_clock", 0, tx_ready[0], 1'b0);
        step();
        for (int i = 0; i < 4; i++) chk("ready_after_release", 0, tx_ready[i], 1'b1);

        // 8N1 single frame 0xA5
        run_frame(0, 8, 0, 1, 9'h0A5, 1'b1, 1'b0, 9'h000, 0);
        check_idle(0);

        // Back-to-back frames with Tx_Valid held high
        run_frame(0, 8, 0, 1, 9'h000, 1'b1, 1'b1, 9'h0FF, 0);
        run_frame(0, 8, 0, 1, 9'h0FF, 1'b0, 1'b1, 9'h03C, 0);
        run_frame(0, 8, 0, 1, 9'h03C, 1'b0, 1'b0, 9'h000, 0);
        check_idle(0);

        // 7E1 and 7O1 with 0x07
        run_frame(1, 7, 2, 1, 9'h007, 1'b1, 1'b0, 9'h000, 0);
        check_idle(1);
        run_frame(2, 7, 1, 1, 9'h007, 1'b1, 1'b0, 9'h000, 0);
        check_idle(2);

        // 9N2 with all ones
        run_frame(3, 9, 0, 2, 9'h1FF, 1'b1, 1'b0, 9'h000, 0);
        check_idle(3);

        // Tx_Valid pulsed mid-frame must be ignored
        run_frame(0, 8, 0, 1, 9'h055, 1'b1, 1'b0, 9'h000, 37);
        check_idle(0);

        // Random words on every configuration
        for (int r = 0; r < 3; r++) begin
            w = 9'($urandom);
            run_frame(0, 8, 0, 1, w, 1'b1, 1'b0, 9'h000, 0);
            check_idle(0);
            w = 9'($urandom);
            run_frame(1, 7, 2, 1, w, 1'b1, 1'b0, 9'h000, 0);
            check_idle(1);
            w = 9'($urandom);
            run_frame(2, 7, 1, 1, w, 1'b1, 1'b0, 9'h000, 0);
            check_idle(2);
            w = 9'($urandom);
            run_frame(3, 9, 0, 2, w, 1'b1, 1'b0, 9'h000, 0);
            check_idle(3);
        end

        // Reset at cycle 43 of an 0xA5 frame
        w           = 9'h0A5;
        tx_word     = w;
        tx_valid[0] = 1'b1;
        step();
        tx_valid[0] = 1'b0;
        for (int k = 1; k <= 42; k++) begin
            e = ((k - 1) / BT == 0) ? 1'b0 : w[(k - 1) / BT - 1];
            chk("abort_serial", k, serial[0], e);
            chk("abort_done",   k, done[0],   1'b0);
            step();
        end
        chk("abort_serial_pre", 43, serial[0], 1'b0);
        rst = 1'b1;
        #1;
        chk("abort_serial_async", 43, serial[0],   1'b1);
        chk("abort_busy_async",   43, busy[0],     1'b0);
        chk("abort_done_async",   43, done[0],     1'b0);
        chk("abort_ready_async",  43, tx_ready[0], 1'b0);
        step();
        chk("abort_serial_held", 0, serial[0], 1'b1);
        chk("abort_done_held",   0, done[0],   1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check_idle(0);
        run_frame(0, 8, 0, 1, 9'h05A, 1'b1, 1'b0, 9'h000, 0);
        check_idle(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
